// File: rtl/cellrv32_cpu_wb_queue.sv
// Write-back queue for the GPR file: serialises long-latency results into the single
// register-file write port and keeps a pending-destination scoreboard for hazard detection.
module cellrv32_cpu_wb_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int REGS  = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              flush_i,
  input  logic              alloc_i,
  input  logic [4:0]        alloc_rd_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [4:0]        req_rd_i,
  input  logic [XLEN-1:0]   req_data_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [4:0]        wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [4:0]        rs3_i,
  output logic              hazard_o,
  output logic              alloc_err_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(REGS);

  logic [XLEN-1:0] data_mem [DEPTH];
  logic [RW-1:0]   rd_mem   [DEPTH];

  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [REGS-1:0] pend_q, pend_d;
  logic            err_q, err_d;

  logic            empty, full, push_en, pop_en, alloc_set;
  logic [RW-1:0]   head_rd, alloc_idx, req_idx;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_rd   = rd_mem[rd_ptr_q[AW-1:0]];
  assign alloc_idx = alloc_rd_i[RW-1:0];
  assign req_idx   = req_rd_i[RW-1:0];

  assign req_ready_o = ~full;
  assign wb_valid_o  = ~empty;
  assign wb_rd_o     = empty ? 5'd0 : 5'(head_rd);
  assign wb_data_o   = empty ? '0 : data_mem[rd_ptr_q[AW-1:0]];
  assign level_o     = level_q;
  assign alloc_err_o = err_q;

  // x0 results complete the handshake but are never stored
  assign push_en   = req_valid_i & req_ready_o & ~flush_i & (req_idx != '0);
  assign pop_en    = wb_valid_o & wb_ready_i;
  assign alloc_set = alloc_i & ~flush_i & (alloc_idx != '0);

  assign hazard_o = pend_q[rs1_i[RW-1:0]] | pend_q[rs2_i[RW-1:0]] | pend_q[rs3_i[RW-1:0]]
                  | (alloc_i & pend_q[alloc_idx]);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    pend_d   = pend_q;
    err_d    = err_q | (alloc_set & pend_q[alloc_idx]);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      pend_d   = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
      // clear before set so a same-cycle re-allocation keeps the bit
      if (pop_en)    pend_d[head_rd]   = 1'b0;
      if (alloc_set) pend_d[alloc_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pend_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      data_mem[wr_ptr_q[AW-1:0]] <= req_data_i;
      rd_mem[wr_ptr_q[AW-1:0]]   <= req_idx;
    end
  end

endmodule
